// File: rtl/frame_buffer_arbiter.sv
// Arbitrates the single-port frame-buffer BRAM between scan-out reads (absolute priority),
// buffered capture writes and a sequenced full-memory clear.
module frame_buffer_arbiter #(
    parameter int unsigned       ADDR_W      = 14,
    parameter int unsigned       DATA_W      = 8,
    parameter int unsigned       FIFO_DEPTH  = 4,
    parameter int unsigned       MEM_WORDS   = 16384,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
    input  logic                          CLK,
    input  logic                          RESET_N,
    input  logic                          RD_EN,
    input  logic [ADDR_W-1:0]             RD_ADDR,
    output logic [DATA_W-1:0]             RD_DATA,
    output logic                          RD_VALID,
    input  logic                          WR_VALID,
    output logic                          WR_READY,
    input  logic [ADDR_W-1:0]             WR_ADDR,
    input  logic [DATA_W-1:0]             WR_DATA,
    input  logic                          CLEAR_REQ,
    output logic                          CLEAR_BUSY,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
    output logic [ADDR_W-1:0]             BRAM_ADDR,
    output logic [DATA_W-1:0]             BRAM_DIN,
    output logic                          BRAM_WE,
    input  logic [DATA_W-1:0]             BRAM_DOUT
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W + 1)'(MEM_WORDS - 1);
    localparam logic [PTR_W:0]  LVL_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StDrain, StClear} state_e;

    state_e state_q, state_d;

    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]    level_q;
    logic [ADDR_W:0]   clr_cnt_q;
    logic              rd_valid_q;

    logic fifo_empty, fifo_full;
    logic push, pop, clear_wr, clear_last;

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == LVL_FULL);
    assign clear_last = (clr_cnt_q == CLR_LAST);

    // State register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (CLEAR_REQ) state_d = StDrain;
            end
            StDrain: begin
                // The drain-complete cycle already carries the write to address 0.
                if (clear_wr) state_d = clear_last ? StIdle : StClear;
            end
            StClear: begin
                if (clear_wr && clear_last) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs and BRAM port mux
    always_comb begin
        WR_READY   = (state_q == StIdle) && !fifo_full;
        CLEAR_BUSY = (state_q != StIdle);
        push       = WR_VALID && WR_READY;
        BRAM_ADDR  = RD_ADDR;
        BRAM_DIN   = fifo_data_q[rd_ptr_q];
        BRAM_WE    = 1'b0;
        pop        = 1'b0;
        clear_wr   = 1'b0;
        if (RD_EN) begin
            BRAM_WE = 1'b0;
        end else if (!fifo_empty) begin
            BRAM_ADDR = fifo_addr_q[rd_ptr_q];
            BRAM_WE   = 1'b1;
            pop       = 1'b1;
        end else if (state_q != StIdle) begin
            BRAM_ADDR = clr_cnt_q[ADDR_W-1:0];
            BRAM_DIN  = CLEAR_VALUE;
            BRAM_WE   = 1'b1;
            clear_wr  = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= WR_ADDR;
            fifo_data_q[wr_ptr_q] <= WR_DATA;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            clr_cnt_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= RD_EN;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   level_q <= level_q + (PTR_W + 1)'(1);
                2'b01:   level_q <= level_q - (PTR_W + 1)'(1);
                default: level_q <= level_q;
            endcase
            // Counter saturates at the last word so a finished clear never wraps to 0.
            if (state_q == StIdle && CLEAR_REQ) begin
                clr_cnt_q <= '0;
            end else if (clear_wr && !clear_last) begin
                clr_cnt_q <= clr_cnt_q + (ADDR_W + 1)'(1);
            end
        end
    end

    assign RD_DATA    = BRAM_DOUT;
    assign RD_VALID   = rd_valid_q;
    assign FIFO_LEVEL = level_q;

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Directed + randomized bench for frame_buffer_arbiter, checked against a queue-based
// reference model and a behavioural BRAM.
module tb_frame_buffer_arbiter;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int MEM    = 16384;
    localparam int M_IDLE  = 0;
    localparam int M_DRAIN = 1;
    localparam int M_CLEAR = 2;

    logic              CLK = 1'b0;
    logic              RESET_N = 1'b1;
    logic              RD_EN, WR_VALID, CLEAR_REQ;
    logic [ADDR_W-1:0] RD_ADDR, WR_ADDR;
    logic [DATA_W-1:0] WR_DATA;
    logic [DATA_W-1:0] RD_DATA, BRAM_DIN, BRAM_DOUT;
    logic              RD_VALID, WR_READY, CLEAR_BUSY, BRAM_WE;
    logic [2:0]        FIFO_LEVEL;
    logic [ADDR_W-1:0] BRAM_ADDR;

    frame_buffer_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .MEM_WORDS(MEM),
        .CLEAR_VALUE(8'h00)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .RD_EN(RD_EN), .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA),
        .RD_VALID(RD_VALID), .WR_VALID(WR_VALID), .WR_READY(WR_READY), .WR_ADDR(WR_ADDR),
        .WR_DATA(WR_DATA), .CLEAR_REQ(CLEAR_REQ), .CLEAR_BUSY(CLEAR_BUSY),
        .FIFO_LEVEL(FIFO_LEVEL), .BRAM_ADDR(BRAM_ADDR), .BRAM_DIN(BRAM_DIN),
        .BRAM_WE(BRAM_WE), .BRAM_DOUT(BRAM_DOUT)
    );

    always #5 CLK = ~CLK;

    // Read-first single-port BRAM
    logic [DATA_W-1:0] bram [MEM];
    always @(posedge CLK) begin
        if (BRAM_WE) bram[BRAM_ADDR] <= BRAM_DIN;
        BRAM_DOUT <= bram[BRAM_ADDR];
    end

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    wr_t               q[$];
    logic [DATA_W-1:0] ref_mem [MEM];
    int                mode, clr;
    bit                exp_rv, dut_acc;
    logic [DATA_W-1:0] exp_rd;
    int                n_checks = 0, n_errors = 0, we_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check combinational outputs, advance the model, check read return.
    task automatic step();
        bit ready, we;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        int mode0;
        #1;
        mode0 = mode;
        ready = (mode == M_IDLE) && (q.size() < DEPTH);
        we = 1'b0; a = RD_ADDR; d = '0;
        if (RD_EN) begin
            we = 1'b0;
        end else if (q.size() > 0) begin
            we = 1'b1; a = q[0].a; d = q[0].d;
        end else if (mode != M_IDLE) begin
            we = 1'b1; a = ADDR_W'(clr); d = 8'h00;
        end
        chk("wr_ready", 32'(WR_READY), 32'(ready));
        chk("bram_we", 32'(BRAM_WE), 32'(we));
        chk("bram_addr", 32'(BRAM_ADDR), 32'(a));
        if (we) chk("bram_din", 32'(BRAM_DIN), 32'(d));
        chk("fifo_level", 32'(FIFO_LEVEL), 32'(q.size()));
        chk("clear_busy", 32'(CLEAR_BUSY), 32'(mode != M_IDLE));
        if (BRAM_WE === 1'b1) we_cnt++;
        dut_acc = (WR_VALID === 1'b1) && (WR_READY === 1'b1);

        exp_rv = RD_EN;
        if (RD_EN) exp_rd = ref_mem[RD_ADDR];
        if (!RD_EN && q.size() > 0) begin
            ref_mem[q[0].a] = q[0].d;
            void'(q.pop_front());
        end else if (!RD_EN && mode != M_IDLE) begin
            ref_mem[clr] = 8'h00;
            if (clr == MEM - 1) mode = M_IDLE;
            else begin
                mode = M_CLEAR;
                clr++;
            end
        end
        if (WR_VALID && ready) q.push_back('{a: WR_ADDR, d: WR_DATA});
        if (mode0 == M_IDLE && CLEAR_REQ) begin
            mode = M_DRAIN;
            clr  = 0;
        end

        @(posedge CLK);
        #1;
        chk("rd_valid", 32'(RD_VALID), 32'(exp_rv));
        if (exp_rv) chk("rd_data", 32'(RD_DATA), 32'(exp_rd));
    endtask

    task automatic do_reset();
        RD_EN = 1'b0; WR_VALID = 1'b0; CLEAR_REQ = 1'b0;
        #2;
        RESET_N = 1'b0;
        #1;
        chk("rst_wr_ready", 32'(WR_READY), 32'd1);
        chk("rst_bram_we", 32'(BRAM_WE), 32'd0);
        chk("rst_bram_addr", 32'(BRAM_ADDR), 32'(RD_ADDR));
        chk("rst_fifo_level", 32'(FIFO_LEVEL), 32'd0);
        chk("rst_rd_valid", 32'(RD_VALID), 32'd0);
        chk("rst_clear_busy", 32'(CLEAR_BUSY), 32'd0);
        q.delete();
        mode = M_IDLE; clr = 0; exp_rv = 1'b0;
        @(posedge CLK);
        #2;
        RESET_N = 1'b1;
        #1;
    endtask

    task automatic write1(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        RD_EN = 1'b0; WR_VALID = 1'b1; WR_ADDR = a; WR_DATA = d;
        step();
        WR_VALID = 1'b0;
        step();
    endtask

    task automatic read1(input logic [ADDR_W-1:0] a);
        RD_EN = 1'b1; RD_ADDR = a; WR_VALID = 1'b0;
        step();
        RD_EN = 1'b0;
    endtask

    int n_acc, idx, guard;

    initial begin
        for (int i = 0; i < MEM; i++) begin
            ref_mem[i] = 8'($urandom);
            bram[i]    = ref_mem[i];
        end
        RD_EN = 0; RD_ADDR = '0; WR_VALID = 0; WR_ADDR = '0; WR_DATA = '0; CLEAR_REQ = 0;
        mode = M_IDLE; clr = 0; exp_rv = 0; exp_rd = '0;
        do_reset();

        // Read priority: continuous reads fill the FIFO
        RD_EN = 1'b1; WR_VALID = 1'b1;
        WR_ADDR = ADDR_W'($urandom); WR_DATA = 8'($urandom);
        n_acc = 0; we_cnt = 0;
        repeat (5) begin
            RD_ADDR = ADDR_W'($urandom);
            step();
            if (dut_acc) begin
                n_acc++;
                WR_ADDR = ADDR_W'($urandom); WR_DATA = 8'($urandom);
            end
        end
        chk("prio_accepted", 32'(n_acc), 32'd4);
        chk("prio_level", 32'(FIFO_LEVEL), 32'd4);
        chk("prio_no_we", 32'(we_cnt), 32'd0);
        RD_EN = 1'b0;
        repeat (6) begin
            step();
            if (dut_acc) WR_VALID = 1'b0;
        end
        chk("prio_fifth_taken", 32'(WR_VALID), 32'd0);

        // Interleave: reads toggle each cycle, writes to 0..9 back-to-back
        idx = 0; guard = 0;
        WR_ADDR = '0; WR_DATA = 8'($urandom); WR_VALID = 1'b1;
        while ((idx < 10 || q.size() > 0) && guard < 60) begin
            RD_EN = ~RD_EN;
            RD_ADDR = ADDR_W'($urandom_range(0, 15));
            step();
            if (dut_acc) begin
                idx++;
                WR_ADDR = ADDR_W'(idx); WR_DATA = 8'($urandom);
                if (idx == 10) WR_VALID = 1'b0;
            end
            guard++;
        end
        WR_VALID = 1'b0;
        chk("ilv_all_accepted", 32'(idx), 32'd10);
        for (int i = 0; i < 10; i++) read1(ADDR_W'(i));

        // Same-address hazard
        write1(14'h1234, 8'hAA);
        RD_EN = 1'b0; WR_VALID = 1'b1; WR_ADDR = 14'h1234; WR_DATA = 8'h55;
        step();
        read1(14'h1234);
        chk("hazard_old", 32'(RD_DATA), 32'hAA);
        step();
        read1(14'h1234);
        chk("hazard_new", 32'(RD_DATA), 32'h55);

        // Reset with writes still queued
        RD_EN = 1'b1; WR_VALID = 1'b1;
        repeat (2) begin
            WR_ADDR = ADDR_W'($urandom); WR_DATA = 8'($urandom);
            step();
        end
        do_reset();

        // Clear with 3 queued writes, reads and offered writes throughout
        RD_EN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            WR_VALID = 1'b1; WR_ADDR = ADDR_W'($urandom); WR_DATA = 8'($urandom);
            step();
        end
        WR_VALID = 1'b0; CLEAR_REQ = 1'b1;
        step();
        CLEAR_REQ = 1'b0;
        guard = 0;
        while (mode != M_IDLE && guard < 30000) begin
            RD_EN = ($urandom_range(0, 3) == 0);
            RD_ADDR = ADDR_W'($urandom);
            WR_VALID = $urandom_range(0, 1);
            WR_ADDR = ADDR_W'($urandom); WR_DATA = 8'($urandom);
            CLEAR_REQ = (guard == 200);
            step();
            guard++;
        end
        RD_EN = 1'b0; WR_VALID = 1'b0; CLEAR_REQ = 1'b0;
        chk("clear_done", 32'(CLEAR_BUSY), 32'd0);
        read1(14'h3FFF);
        chk("clear_last_word", 32'(RD_DATA), 32'h00);
        repeat (8) read1(ADDR_W'($urandom));

        // Reset mid-clear at address 0x0100
        write1(14'h00FF, 8'h11);
        write1(14'h0100, 8'h5A);
        write1(14'h2000, 8'hC3);
        CLEAR_REQ = 1'b1;
        step();
        CLEAR_REQ = 1'b0;
        guard = 0;
        while (!(mode == M_CLEAR && clr == 14'h0100) && guard < 2000) begin
            RD_EN = ($urandom_range(0, 3) == 0);
            RD_ADDR = ADDR_W'($urandom);
            step();
            guard++;
        end
        chk("midclr_busy", 32'(CLEAR_BUSY), 32'd1);
        do_reset();
        step();
        chk("midclr_idle", 32'(CLEAR_BUSY), 32'd0);
        read1(14'h00FF);
        chk("midclr_cleared", 32'(RD_DATA), 32'h00);
        read1(14'h0100);
        chk("midclr_kept_100", 32'(RD_DATA), 32'h5A);
        read1(14'h2000);
        chk("midclr_kept_2000", 32'(RD_DATA), 32'hC3);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
